// File: rtl/tank_game_pkg.sv
// tank_game_pkg: shared encodings for the tank game logic.
// Holds facing/flight direction codes, playfield grid limits and the
// bullet launcher FSM state codes.
package tank_game_pkg;
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;
    localparam logic [4:0] GRID_X_MAX = 5'd31;
    localparam logic [4:0] GRID_Y_MAX = 5'd23;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARM      = 3'd1;
    localparam logic [2:0] FLY      = 3'd2;
    localparam logic [2:0] HIT      = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;
    localparam logic [2:0] COOLDOWN = 3'd5;
endpackage

// File: rtl/bullet_launcher_if.sv
// bullet_launcher_if: link between the launcher (master) and the bullet module (slave).
// bul_state/bul_dir/x,y_bul_pos_in: launch control from launcher to bullet.
// x,y_bul_pos_out: bullet's current grid cell returned to the launcher.
interface bullet_launcher_if;
    logic       bul_state;
    logic [1:0] bul_dir;
    logic [4:0] x_bul_pos_in;
    logic [4:0] y_bul_pos_in;
    logic [4:0] x_bul_pos_out;
    logic [4:0] y_bul_pos_out;
    modport master (
        output bul_state, bul_dir, x_bul_pos_in, y_bul_pos_in,
        input  x_bul_pos_out, y_bul_pos_out
    );
    modport slave (
        input  bul_state, bul_dir, x_bul_pos_in, y_bul_pos_in,
        output x_bul_pos_out, y_bul_pos_out
    );
endinterface

// File: rtl/bul_edge_chk.sv
// bul_edge_chk: flags a bullet sitting on the playfield edge it is travelling toward.
// Ports: x, y (grid cell), dir (travel direction) in; at_edge out.
module bul_edge_chk
    import tank_game_pkg::*;
#(
    parameter logic [4:0] X_MAX = GRID_X_MAX,
    parameter logic [4:0] Y_MAX = GRID_Y_MAX
) (
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [1:0] dir,
    output logic       at_edge
);
    assign at_edge = dir == DIR_UP   ? y == 5'd0  :
                     dir == DIR_DOWN ? y == Y_MAX :
                     dir == DIR_LEFT ? x == 5'd0  : x == X_MAX;
endmodule

// File: rtl/bullet_launcher.sv
// bullet_launcher: owns a tank's single bullet, launches it, detects hit/edge, enforces cooldown.
// Ports: clk_8Hz game tick; rst_n async active-low reset; fire debounced key level;
// tank_dir, x/y_tank_pos shooter pose; x/y_enemy_pos enemy cell (sampled live);
// bus (master) launch control to and position feedback from the bullet module;
// hit one-tick strike pulse; score saturating hit count; busy high outside IDLE.
// Build option: define BULLET_AUTO_FIRE_EN to relaunch straight from COOLDOWN while fire is held.
module bullet_launcher
    import tank_game_pkg::*;
#(
    parameter int X_MAX      = 31,
    parameter int Y_MAX      = 23,
    parameter int COOL_TICKS = 4,
    parameter int FLIGHT_MAX = 40
) (
    input  logic               clk_8Hz,
    input  logic               rst_n,
    input  logic               fire,
    input  logic [1:0]         tank_dir,
    input  logic [4:0]         x_tank_pos,
    input  logic [4:0]         y_tank_pos,
    input  logic [4:0]         x_enemy_pos,
    input  logic [4:0]         y_enemy_pos,
    bullet_launcher_if.master  bus,
    output logic               hit,
    output logic [7:0]         score,
    output logic               busy
);
    logic [2:0] state;
    logic       fire_d;
    logic [5:0] flight_cnt;
    logic [3:0] cool_cnt;
    logic       at_edge;
    logic       on_enemy;
    logic       cool_end;
    logic       relaunch;
    logic       launch;

    bul_edge_chk #(.X_MAX(5'(X_MAX)), .Y_MAX(5'(Y_MAX))) u_edge (
        .x       (bus.x_bul_pos_out),
        .y       (bus.y_bul_pos_out),
        .dir     (bus.bul_dir),
        .at_edge (at_edge)
    );

`ifdef BULLET_AUTO_FIRE_EN
    assign relaunch = fire;
`else
    assign relaunch = 1'b0;
`endif

    assign on_enemy = bus.x_bul_pos_out == x_enemy_pos && bus.y_bul_pos_out == y_enemy_pos;
    assign cool_end = state == COOLDOWN && cool_cnt == 4'd1;
    assign launch   = (state == IDLE && fire && !fire_d) || (cool_end && relaunch);
    assign busy     = state != IDLE;

    always_ff @(posedge clk_8Hz or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            fire_d           <= 1'b0;
            flight_cnt       <= '0;
            cool_cnt         <= '0;
            hit              <= 1'b0;
            score            <= '0;
            bus.bul_state    <= 1'b0;
            bus.bul_dir      <= '0;
            bus.x_bul_pos_in <= '0;
            bus.y_bul_pos_in <= '0;
        end else begin
            fire_d <= fire;
            hit    <= 1'b0;
            case (state)
                ARM: begin
                    state      <= FLY;
                    flight_cnt <= '0;
                end
                FLY: begin
                    if (on_enemy) begin
                        state         <= HIT;
                        hit           <= 1'b1;
                        bus.bul_state <= 1'b0;
                        score         <= score == 8'hFF ? score : score + 8'd1;
                    end else if (at_edge || flight_cnt == 6'(FLIGHT_MAX - 1)) begin
                        state         <= DONE;
                        bus.bul_state <= 1'b0;
                    end else begin
                        flight_cnt <= flight_cnt + 6'd1;
                    end
                end
                HIT, DONE: begin
                    state    <= COOLDOWN;
                    cool_cnt <= 4'(COOL_TICKS);
                end
                COOLDOWN: begin
                    cool_cnt <= cool_cnt - 4'd1;
                    state    <= cool_end ? IDLE : COOLDOWN;
                end
                default: state <= IDLE;
            endcase
            // A launch overrides the IDLE hold or the COOLDOWN exit chosen above.
            if (launch) begin
                state            <= ARM;
                bus.bul_state    <= 1'b1;
                bus.bul_dir      <= tank_dir;
                bus.x_bul_pos_in <= x_tank_pos;
                bus.y_bul_pos_in <= y_tank_pos;
            end
        end
    end
endmodule

// File: doc/bullet_launcher.md
Name: bullet_launcher

Overview:
- Game-logic controller that owns a tank's single bullet and drives the bullet module as its initiator.
- On a fire request it loads the bullet's launch position and direction, and raises bul_state.
- It watches the bullet's returned grid position for a hit on the enemy tank or for reaching the playfield edge, then retires the bullet and enforces a cooldown.
- Sits between the debounced key/tank logic and the bullet module; clocked by the 8 Hz game tick.

Parameters:
- X_MAX, 31, last grid column (5-bit grid, 20-pixel cells).
- Y_MAX, 23, last grid row.
- COOL_TICKS, 4, number of clk_8Hz cycles spent in COOLDOWN (1..15).
- FLIGHT_MAX, 40, safety timeout on flight length in ticks (1..63).

Ports:
- clk_8Hz  in  1  game tick clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- fire  in  1  debounced fire key, level.
- tank_dir  in  2  shooter facing: 00 up, 01 down, 10 left, 11 right.
- x_tank_pos  in  5  shooter grid column.
- y_tank_pos  in  5  shooter grid row.
- x_enemy_pos  in  5  enemy grid column.
- y_enemy_pos  in  5  enemy grid row.
- x_bul_pos_out  in  5  bullet's current column, returned by the bullet module.
- y_bul_pos_out  in  5  bullet's current row, returned by the bullet module.
- bul_state  out  1  1 = bullet alive; drives the bullet module.
- bul_dir  out  2  latched flight direction.
- x_bul_pos_in  out  5  launch column.
- y_bul_pos_in  out  5  launch row.
- hit  out  1  one-tick pulse when the enemy is struck.
- score  out  8  saturating hit counter.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs 0: bul_state, bul_dir, x/y_bul_pos_in, hit, score, busy.
  - fire_d=0; flight and cooldown counters 0.
- Fire edge: fire_rise = fire & ~fire_d; fire_d is registered each tick.
- IDLE: on fire_rise -> ARM. In the same edge, latch bul_dir=tank_dir, x/y_bul_pos_in=tank position, bul_state=1.
- ARM (one tick):
  - The bullet module loads its position this tick, so no checks are made.
  - Go to FLY and clear the flight counter.
- FLY: evaluated each tick in this priority order:
  1. Bullet position equals enemy position -> HIT.
  2. Bullet on the edge in its travel direction -> DONE. Edge means y==0 moving up, y==Y_MAX moving down, x==0 moving left, x==X_MAX moving right.
  3. Flight counter == FLIGHT_MAX-1 -> DONE.
  4. Otherwise increment the flight counter and stay in FLY.
- HIT:
  - hit=1 for exactly this tick; bul_state=0.
  - score increments, saturating at 255.
  - Load the cooldown counter and go to COOLDOWN.
- DONE: bul_state=0; load the cooldown counter; go to COOLDOWN.
- COOLDOWN: decrement each tick; after COOL_TICKS ticks go to IDLE.
- Fire during ARM, FLY, HIT, DONE or COOLDOWN is ignored. fire_d still updates, so a held key needs a release and re-press.
- Launch position already equals the enemy position: the hit is detected on the first FLY tick, i.e. the 2nd tick after fire_rise.
- Launch from an edge cell facing outward: DONE on the first FLY tick; the bullet is alive for 2 ticks.
- Direction, launch-position and enemy changes during flight: bul_dir and the launch position stay latched. Enemy inputs are sampled live.
- busy = (state != IDLE).
- Reset mid-flight drops bul_state at once (asynchronously); score clears.

Optional Feature:
- Macro: BULLET_AUTO_FIRE_EN.
- Defined: when COOLDOWN completes with fire still high, go directly to ARM, relaunching with the current tank_dir and position. No new edge is needed.
- Undefined: COOLDOWN always returns to IDLE, and firing requires a fresh fire_rise.

Decomposition:
- Shared package (tank_game_pkg) holds:
  - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT encodings.
  - GRID_X_MAX/GRID_Y_MAX.
  - State encodings IDLE/ARM/FLY/HIT/DONE/COOLDOWN.
- One combinational sub-module, bul_edge_chk, is natural: inputs x, y, dir; output at_edge. It is reusable by the enemy-AI shooter.

Test Plan:
- Reset, then fire pulse with tank (10,10) dir right, enemy (14,10):
  - bul_state=1, x_bul_pos_in=10, bul_dir=11 one tick after fire_rise.
  - When the model bullet reaches x=14: hit=1 for one tick, score=1, bul_state=0.
  - busy falls 4 ticks later.
- Tank (31,5) dir right, enemy elsewhere, fire: DONE on the first FLY tick; hit=0; score unchanged.
- Second fire pulse while in FLY and during COOLDOWN: no relaunch; bul_dir/pos_in unchanged.
- Force score=255 and score a hit: score stays 255; hit still pulses.
- Model bullet that never moves (stuck at (5,5)), no enemy: DONE after FLIGHT_MAX=40 FLY ticks.
- Fire held high through cooldown:
  - With BULLET_AUTO_FIRE_EN: relaunch (bul_state=1) the tick after COOLDOWN ends.
  - Without it: stays IDLE until fire goes 0 then 1.
- rst_n low mid-FLY: bul_state=0 and score=0 immediately, without waiting for a clock edge.
